dmem_arbiter: RTL and testbench

- Two-master arbiter and sequencer in front of the single-port data memory: 256 words, combinational read, write on rising clk when mem_write=1, word index addr[31:2].
- Master 0 is the CPU load/store path; master 1 is the debug/DMA loader.
- Round-robin grant, one access per cycle, registered command stage, and a fixed-latency response with per-access error flag.
- Also maintains a saturating contention counter for performance monitoring.

---
 rtl/dmem_arbiter.sv | 152 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-master round-robin arbiter in front of a single-port data memory.
// It has a registered command stage, a response two cycles after the grant, and a contention counter.
module dmem_arbiter #(
  parameter int DEPTH = 256,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             m0_req,
  input  logic             m0_we,
  input  logic [31:0]      m0_addr,
  input  logic [31:0]      m0_wdata,
  output logic             m0_gnt,
  output logic             m0_rvalid,
  output logic [31:0]      m0_rdata,
  output logic             m0_err,
  input  logic             m1_req,
  input  logic             m1_we,
  input  logic [31:0]      m1_addr,
  input  logic [31:0]      m1_wdata,
  output logic             m1_gnt,
  output logic             m1_rvalid,
  output logic [31:0]      m1_rdata,
  output logic             m1_err,
  output logic             mem_write,
  output logic             mem_read,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wd,
  input  logic [31:0]      mem_rd,
  output logic [CNT_W-1:0] conflict_cnt
);

  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  // Handshake: a master raises req with stable we/addr/wdata.
  // gnt is combinational in the same cycle, and the transfer happens when req&gnt.
  // A master holds its request until it is granted; rvalid follows 2 cycles after the grant.
  logic             last_grant_q, last_grant_d;
  logic             cmd_valid_q, cmd_valid_d;
  logic             cmd_id_q, cmd_id_d;
  logic             cmd_we_q, cmd_we_d;
  logic [31:0]      cmd_addr_q, cmd_addr_d;
  logic [31:0]      cmd_wd_q, cmd_wd_d;
  logic [1:0]       rvalid_q, rvalid_d;
  logic [31:0]      m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;
  logic             m0_err_q, m0_err_d, m1_err_q, m1_err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        gnt_any;
  logic        gnt_id;
  logic        bad;
  logic [31:0] resp_rdata;

  always_comb begin
    gnt_any = rst_n & (m0_req | m1_req);
    // On a tie the master that did not win last time gets the grant; otherwise the sole requester wins.
    if (m0_req & m1_req) gnt_id = ~last_grant_q;
    else                 gnt_id = ~m0_req;
  end

  assign m0_gnt = gnt_any & ~gnt_id;
  assign m1_gnt = gnt_any & gnt_id;

  always_comb begin
    bad = (cmd_addr_q[1:0] != 2'b00) | ({2'b00, cmd_addr_q[31:2]} >= DEPTH_W);
  end

  assign mem_addr  = cmd_addr_q;
  assign mem_wd    = cmd_wd_q;
  assign mem_write = rst_n & cmd_valid_q & cmd_we_q & ~bad;
  assign mem_read  = cmd_valid_q & ~cmd_we_q & ~bad;

  always_comb begin
    last_grant_d = last_grant_q;
    cmd_valid_d  = gnt_any;
    cmd_id_d     = cmd_id_q;
    cmd_we_d     = cmd_we_q;
    cmd_addr_d   = cmd_addr_q;
    cmd_wd_d     = cmd_wd_q;
    if (gnt_any) begin
      last_grant_d = gnt_id;
      cmd_id_d     = gnt_id;
      cmd_we_d     = gnt_id ? m1_we    : m0_we;
      cmd_addr_d   = gnt_id ? m1_addr  : m0_addr;
      cmd_wd_d     = gnt_id ? m1_wdata : m0_wdata;
    end
  end

  always_comb begin
    resp_rdata = (cmd_we_q | bad) ? 32'd0 : mem_rd;
    rvalid_d   = 2'b00;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
    m0_err_d   = m0_err_q;
    m1_err_d   = m1_err_q;
    if (cmd_valid_q) begin
      if (cmd_id_q) begin
        rvalid_d   = 2'b10;
        m1_rdata_d = resp_rdata;
        m1_err_d   = bad;
      end else begin
        rvalid_d   = 2'b01;
        m0_rdata_d = resp_rdata;
        m0_err_d   = bad;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (m0_req & m1_req & ~(&cnt_q)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
      cmd_valid_q  <= 1'b0;
      cmd_id_q     <= 1'b0;
      cmd_we_q     <= 1'b0;
      cmd_addr_q   <= 32'd0;
      cmd_wd_q     <= 32'd0;
      rvalid_q     <= 2'b00;
      m0_rdata_q   <= 32'd0;
      m1_rdata_q   <= 32'd0;
      m0_err_q     <= 1'b0;
      m1_err_q     <= 1'b0;
      cnt_q        <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_id_q     <= cmd_id_d;
      cmd_we_q     <= cmd_we_d;
      cmd_addr_q   <= cmd_addr_d;
      cmd_wd_q     <= cmd_wd_d;
      rvalid_q     <= rvalid_d;
      m0_rdata_q   <= m0_rdata_d;
      m1_rdata_q   <= m1_rdata_d;
      m0_err_q     <= m0_err_d;
      m1_err_q     <= m1_err_d;
      cnt_q        <= cnt_d;
    end
  end

  assign m0_rvalid    = rvalid_q[0];
  assign m1_rvalid    = rvalid_q[1];
  assign m0_rdata     = m0_rdata_q;
  assign m1_rdata     = m1_rdata_q;
  assign m0_err       = m0_err_q;
  assign m1_err       = m1_err_q;
  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random two-master traffic.
// Checks against an access-level reference model of grants, memory and responses.
module tb_dmem_arbiter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_write, mem_read;
  logic [31:0] mem_addr, mem_wd, mem_rd;
  logic [15:0] conflict_cnt;

  logic        s_m0_gnt, s_m0_rvalid, s_m0_err, s_m1_gnt, s_m1_rvalid, s_m1_err;
  logic [31:0] s_m0_rdata, s_m1_rdata;
  logic        s_mem_write, s_mem_read;
  logic [31:0] s_mem_addr, s_mem_wd, s_mem_rd;
  logic [3:0]  s_cnt;

  dmem_arbiter #(.DEPTH(256), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .mem_write(mem_write), .mem_read(mem_read), .mem_addr(mem_addr), .mem_wd(mem_wd),
    .mem_rd(mem_rd), .conflict_cnt(conflict_cnt)
  );

  // Narrow-counter instance, used only for saturation of conflict_cnt.
  dmem_arbiter #(.DEPTH(256), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(s_m0_gnt), .m0_rvalid(s_m0_rvalid), .m0_rdata(s_m0_rdata), .m0_err(s_m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(s_m1_gnt), .m1_rvalid(s_m1_rvalid), .m1_rdata(s_m1_rdata), .m1_err(s_m1_err),
    .mem_write(s_mem_write), .mem_read(s_mem_read), .mem_addr(s_mem_addr), .mem_wd(s_mem_wd),
    .mem_rd(s_mem_rd), .conflict_cnt(s_cnt)
  );

  // Physical memory attached to the main DUT.
  logic [31:0] mem [0:255];
  assign mem_rd   = mem[mem_addr[9:2]];
  assign s_mem_rd = mem[s_mem_addr[9:2]];
  always @(posedge clk) if (mem_write) mem[mem_addr[9:2]] <= mem_wd;

  // ---------------- reference model / scoreboard ----------------
  typedef struct packed {
    logic [31:0] gc;
    logic        id;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
  } acc_t;

  acc_t        acc_q[$];
  logic [65:0] exp_q[$];
  logic [31:0] ref_mem [0:255];
  logic [31:0] held_rd [2];
  logic        held_err [2];
  logic        last_g;
  int          cnt;
  int          cyc;
  int          n_cmp, n_err;
  int          rv_cnt0, rv_cnt1;
  logic        chk_en;
  logic        got0, got1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic model_cycle();
    acc_t        a, n;
    logic        have, badx, both, gany, gid;
    logic [65:0] e;
    logic [1:0]  exp_rv;
    logic [31:0] rd;
    logic [7:0]  idx;
    a = '0;
    have = 1'b0;
    if (acc_q.size() > 0 && acc_q[0].gc == 32'(cyc - 1)) begin
      a = acc_q.pop_front();
      have = 1'b1;
    end
    badx = (a.addr[1:0] != 2'b00) || ((a.addr >> 2) >= 32'd256);
    chk("mem_write", mem_write, have && rst_n && a.we && !badx);
    chk("mem_read", mem_read, have && !a.we && !badx);
    if (have) begin
      chk("mem_addr", mem_addr, a.addr);
      chk("mem_wd", mem_wd, a.wd);
    end

    exp_rv = 2'b00;
    if (exp_q.size() > 0 && exp_q[0][65:34] == 32'(cyc)) begin
      e = exp_q.pop_front();
      exp_rv[e[33]] = 1'b1;
      held_rd[e[33]] = e[31:0];
      held_err[e[33]] = e[32];
    end
    chk("m0_rvalid", m0_rvalid, exp_rv[0]);
    chk("m1_rvalid", m1_rvalid, exp_rv[1]);
    chk("m0_rdata", m0_rdata, held_rd[0]);
    chk("m1_rdata", m1_rdata, held_rd[1]);
    chk("m0_err", m0_err, held_err[0]);
    chk("m1_err", m1_err, held_err[1]);
    rv_cnt0 += int'(m0_rvalid);
    rv_cnt1 += int'(m1_rvalid);

    if (have && rst_n) begin
      idx = a.addr[9:2];
      if (!badx && a.we) ref_mem[idx] = a.wd;
      rd = (!badx && !a.we) ? ref_mem[idx] : 32'd0;
      exp_q.push_back({32'(cyc + 1), a.id, badx, rd});
    end

    both = m0_req && m1_req;
    gany = rst_n && (m0_req || m1_req);
    gid  = both ? !last_g : m1_req;
    chk("m0_gnt", m0_gnt, gany && !gid);
    chk("m1_gnt", m1_gnt, gany && gid);
    got0 = m0_gnt;
    got1 = m1_gnt;
    if (gany) begin
      n.gc   = 32'(cyc);
      n.id   = gid;
      n.we   = gid ? m1_we    : m0_we;
      n.addr = gid ? m1_addr  : m0_addr;
      n.wd   = gid ? m1_wdata : m0_wdata;
      acc_q.push_back(n);
      last_g = gid;
    end

    chk("conflict_cnt", conflict_cnt, 32'(cnt));
    chk("conflict_cnt4", s_cnt, (cnt > 15) ? 32'd15 : 32'(cnt));
    if (rst_n && both && cnt < 65535) cnt++;

    if (!rst_n) begin
      acc_q.delete();
      exp_q.delete();
      held_rd[0] = 32'd0;  held_rd[1] = 32'd0;
      held_err[0] = 1'b0;  held_err[1] = 1'b0;
      last_g = 1'b1;
      cnt = 0;
    end
  endtask

  always @(negedge clk) if (chk_en) model_cycle();

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_m0(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wd);
    m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wd;
  endtask

  task automatic set_m1(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wd);
    m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wd;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_m0(1'b0, 1'b0, 32'd0, 32'd0);
    set_m1(1'b0, 1'b0, 32'd0, 32'd0);
    tick(2);
    rst_n = 1'b1;
  endtask

  task automatic gen(output logic we, output logic [31:0] addr, output logic [31:0] wd);
    int r;
    r = $urandom_range(0, 9);
    we = 1'($urandom_range(0, 1));
    wd = $urandom;
    if (r == 0)      addr = {22'd0, 8'($urandom_range(0, 255)), 2'($urandom_range(1, 3))};
    else if (r == 1) addr = 32'h400 + 32'($urandom_range(0, 4095));
    else             addr = {22'd0, 8'($urandom_range(0, 15)), 2'b00};
  endtask

  // ---------------- stimulus ----------------
  logic [5:0] gseq;
  logic       nwe;
  logic [31:0] naddr, nwd;

  initial begin
    n_cmp = 0; n_err = 0; cyc = 0; chk_en = 1'b0;
    cnt = 0; last_g = 1'b1; rv_cnt0 = 0; rv_cnt1 = 0;
    held_rd[0] = 32'd0; held_rd[1] = 32'd0; held_err[0] = 1'b0; held_err[1] = 1'b0;
    got0 = 1'b0; got1 = 1'b0;
    for (int i = 0; i < 256; i++) begin
      logic [31:0] v;
      v = (i == 0) ? 32'h0BAD_F00D : (i == 8) ? 32'h8888_8888 : $urandom;
      mem[i] <= v;
      ref_mem[i] = v;
    end
    rst_n = 1'b0;
    set_m0(1'b0, 1'b0, 32'd0, 32'd0);
    set_m1(1'b0, 1'b0, 32'd0, 32'd0);
    tick(1);
    chk_en = 1'b1;
    tick(2);
    rst_n = 1'b1;

    // write then read back on master 0
    set_m0(1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
    tick(1);
    m0_req = 1'b0;
    @(negedge clk);
    chk("t1_mem_write", mem_write, 1);
    chk("t1_mem_addr", mem_addr, 32'h10);
    tick(1);
    @(negedge clk);
    chk("t1_wr_rvalid", m0_rvalid, 1);
    chk("t1_wr_err", m0_err, 0);
    tick(1);
    set_m0(1'b1, 1'b0, 32'h10, 32'd0);
    tick(1);
    m0_req = 1'b0;
    tick(1);
    @(negedge clk);
    chk("t1_rd_rvalid", m0_rvalid, 1);
    chk("t1_rd_data", m0_rdata, 32'hDEADBEEF);
    tick(1);

    // continuous contention for 6 cycles
    do_reset();
    rv_cnt0 = 0; rv_cnt1 = 0;
    set_m0(1'b1, 1'b0, 32'h10, 32'd0);
    set_m1(1'b1, 1'b0, 32'h20, 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      gseq[i] = m1_gnt;
      tick(1);
    end
    m0_req = 1'b0; m1_req = 1'b0;
    tick(3);
    chk("t2_grant_seq", 32'(gseq), 32'h2A);
    chk("t2_rv0", rv_cnt0, 3);
    chk("t2_rv1", rv_cnt1, 3);
    chk("t2_cnt", conflict_cnt, 6);

    // back-to-back write then read on master 1
    set_m1(1'b1, 1'b1, 32'h3FC, 32'h12345678);
    tick(1);
    set_m1(1'b1, 1'b0, 32'h3FC, 32'd0);
    tick(1);
    m1_req = 1'b0;
    tick(1);
    @(negedge clk);
    chk("t3_rvalid", m1_rvalid, 1);
    chk("t3_rdata", m1_rdata, 32'h12345678);
    tick(1);

    // out-of-range write and misaligned read
    set_m0(1'b1, 1'b1, 32'h400, 32'h55AA55AA);
    tick(1);
    set_m0(1'b1, 1'b0, 32'h13, 32'd0);
    tick(1);
    m0_req = 1'b0;
    @(negedge clk);
    chk("t4_wr_rvalid", m0_rvalid, 1);
    chk("t4_wr_err", m0_err, 1);
    chk("t4_wr_rdata", m0_rdata, 0);
    tick(1);
    @(negedge clk);
    chk("t4_rd_err", m0_err, 1);
    chk("t4_rd_rdata", m0_rdata, 0);
    tick(1);
    chk("t4_mem0", mem[0], 32'h0BAD_F00D);

    // reset while a write is in the command stage
    set_m0(1'b1, 1'b1, 32'h20, 32'hCAFEF00D);
    tick(1);
    rst_n = 1'b0;
    m0_req = 1'b0;
    @(negedge clk);
    chk("t5_mem_write", mem_write, 0);
    tick(1);
    rst_n = 1'b1;
    set_m0(1'b1, 1'b0, 32'h0, 32'd0);
    set_m1(1'b1, 1'b0, 32'h4, 32'd0);
    @(negedge clk);
    chk("t5_rvalid", m0_rvalid, 0);
    chk("t5_cnt", conflict_cnt, 0);
    chk("t5_first_win", m0_gnt, 1);
    chk("t5_mem8", mem[8], 32'h8888_8888);
    tick(1);
    m0_req = 1'b0; m1_req = 1'b0;
    tick(3);

    // saturation of the narrow counter
    do_reset();
    set_m0(1'b1, 1'b0, 32'h0, 32'd0);
    set_m1(1'b1, 1'b0, 32'h4, 32'd0);
    tick(20);
    m0_req = 1'b0; m1_req = 1'b0;
    tick(3);
    chk("t6_cnt4_sat", s_cnt, 15);
    chk("t6_cnt16", conflict_cnt, 20);

    // random traffic obeying the hold-until-granted rule
    for (int k = 0; k < 3000; k++) begin
      if (!(m0_req && !got0)) begin
        gen(nwe, naddr, nwd);
        set_m0($urandom_range(0, 9) < 6, nwe, naddr, nwd);
      end
      if (!(m1_req && !got1)) begin
        gen(nwe, naddr, nwd);
        set_m1($urandom_range(0, 9) < 6, nwe, naddr, nwd);
      end
      rst_n = ($urandom_range(0, 199) != 0);
      tick(1);
    end
    rst_n = 1'b1;
    m0_req = 1'b0; m1_req = 1'b0;
    tick(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
